// File: rtl/polar_encoder_stream.sv
`default_nettype none
// =============================================================================
// Module : polar_encoder_stream
// Brief  : Serial info-bit collector with frozen-bit insertion feeding LOG2N
//          registered polar butterfly stages; valid/ready on both sides.
// Rev    : 1.0
// =============================================================================
module polar_encoder_stream #(
  parameter int           N           = 8,
  parameter int           K           = 4,
  parameter logic [N-1:0] FROZEN_MASK = 8'b0001_0111,
  parameter int           LOG2N       = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_bit,
  input  logic         in_last,
  output logic         cw_valid,
  input  logic         cw_ready,
  output logic [N-1:0] cw_data,
  output logic         err_frame
);

  localparam int CNT_W = (K > 1) ? $clog2(K) : 1;

  if ((N < 2) || (N > 1024) || ((N & (N - 1)) != 0) || (LOG2N != $clog2(N))) begin : g_chk_n
    $error("polar_encoder_stream: N must be a power of two in 2..1024 and LOG2N must not be overridden");
  end
  if ($countones(~FROZEN_MASK) != K) begin : g_chk_k
    $error("polar_encoder_stream: K must equal the number of non-frozen positions");
  end

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    FULL    = 1'b1
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [N-1:0]     r_u, w_u_nxt, w_sel;
  logic             r_err, w_err_nxt;
  logic             w_move, w_beat, w_kth;
  logic [LOG2N-1:0] w_sv, w_free;
  logic [N-1:0]     w_sd  [LOG2N];
  logic [N-1:0]     w_src [LOG2N];
  logic [N-1:0]     w_bf  [LOG2N];

  // One-hot write enable: the info position whose rank among non-frozen bits equals the counter
  for (genvar i = 0; i < N; i++) begin : g_sel
    if (FROZEN_MASK[i]) begin : g_frozen
      assign w_sel[i] = 1'b0;
    end else begin : g_info
      localparam logic [N-1:0] BELOW = (N'(1) << i) - N'(1);
      localparam int           RANK  = $countones(~FROZEN_MASK & BELOW);
      assign w_sel[i] = (r_cnt == CNT_W'(RANK));
    end
  end

  // A stage may load when it is empty or its contents leave this cycle
  always_comb begin
    logic w_down;
    w_down = cw_ready;
    for (int s = LOG2N - 1; s >= 0; s--) begin
      w_free[s] = !w_sv[s] || w_down;
      w_down    = w_free[s];
    end
  end

  assign w_move   = (r_state == FULL) && w_free[0];
  assign in_ready = rst_n && ((r_state == COLLECT) || w_move);
  assign w_beat   = in_valid && in_ready;
  assign w_kth    = (r_cnt == CNT_W'(K - 1));

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_u_nxt     = w_move ? '0 : r_u;
    w_err_nxt   = 1'b0;
    if (w_beat) begin
      w_u_nxt = (w_u_nxt & ~w_sel) | ({N{in_bit}} & w_sel);
      if (w_kth) begin
        w_state_nxt = FULL;
        w_cnt_nxt   = '0;
        w_err_nxt   = !in_last;
      end else if (in_last) begin
        w_state_nxt = COLLECT;
        w_cnt_nxt   = '0;
        w_u_nxt     = '0;
        w_err_nxt   = 1'b1;
      end else begin
        w_state_nxt = COLLECT;
        w_cnt_nxt   = r_cnt + CNT_W'(1);
      end
    end else if (w_move) begin
      w_state_nxt = COLLECT;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= COLLECT;
      r_cnt   <= '0;
      r_u     <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_u     <= w_u_nxt;
      r_err   <= w_err_nxt;
    end
  end

  for (genvar s = 0; s < LOG2N; s++) begin : g_stage
    logic         r_v;
    logic [N-1:0] r_d;
    logic         w_in_v;

    if (s == 0) begin : g_first
      assign w_src[s] = r_u;
      assign w_in_v   = w_move;
    end else begin : g_next
      assign w_src[s] = w_sd[s-1];
      assign w_in_v   = w_sv[s-1];
    end

    // Butterfly of span 2^s: upper index of each pair absorbs its partner
    for (genvar i = 0; i < N; i++) begin : g_bfly
      if (((i >> s) & 1) == 0) begin : g_top
        assign w_bf[s][i] = w_src[s][i] ^ w_src[s][i + (1 << s)];
      end else begin : g_bot
        assign w_bf[s][i] = w_src[s][i];
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_v <= 1'b0;
        r_d <= '0;
      end else if (w_free[s]) begin
        r_v <= w_in_v;
        if (w_in_v) begin
          r_d <= w_bf[s];
        end
      end
    end

    assign w_sv[s] = r_v;
    assign w_sd[s] = r_d;
  end

  assign cw_valid  = w_sv[LOG2N-1];
  assign cw_data   = w_sd[LOG2N-1];
  assign err_frame = r_err;

endmodule
`default_nettype wire

// File: tb/tb_polar_encoder_stream.sv
`default_nettype none
// =============================================================================
// Module : tb_polar_encoder_stream
// Brief  : Directed self-checking bench; frame-level scoreboard for codewords.
// Rev    : 1.0
// =============================================================================
module tb_polar_encoder_stream;
  localparam int           N    = 8;
  localparam int           K    = 4;
  localparam logic [N-1:0] MASK = 8'b0001_0111;

  logic         clk = 1'b0;
  logic         rst_n, in_valid, in_ready, in_bit, in_last;
  logic         cw_valid, cw_ready, err_frame;
  logic [N-1:0] cw_data;

  int           n_chk = 0;
  int           n_fail = 0;
  int           cyc = 0;
  int           last_beat_cyc = 0;
  int           err_seen = 0;
  int           m_cnt = 0;
  logic [K-1:0] m_bits = '0;
  bit           err_exp = 1'b0;
  bit           prev_stall = 1'b0;
  bit           after_rst = 1'b0;
  logic [N-1:0] prev_data = '0;
  logic [N-1:0] exp_q[$];
  logic [N-1:0] out_data[$];
  int           out_cyc[$];

  polar_encoder_stream #(.N(N), .K(K), .FROZEN_MASK(MASK)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bit    (in_bit),
    .in_last   (in_last),
    .cw_valid  (cw_valid),
    .cw_ready  (cw_ready),
    .cw_data   (cw_data),
    .err_frame (err_frame)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [N-1:0] build_u(input logic [K-1:0] bits);
    logic [N-1:0] u;
    int k;
    u = '0;
    k = 0;
    for (int i = 0; i < N; i++) begin
      if (((MASK >> i) & N'(1)) == '0) begin
        if (((bits >> k) & K'(1)) != '0) u = u | (N'(1) << i);
        k++;
      end
    end
    return u;
  endfunction

  // x[j] = XOR of u[i] over all i that contain j
  function automatic logic [N-1:0] encode(input logic [N-1:0] u);
    logic [N-1:0] x;
    logic p;
    x = '0;
    for (int j = 0; j < N; j++) begin
      p = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (((i & j) == j) && (((u >> i) & N'(1)) != '0)) p = ~p;
      end
      if (p) x = x | (N'(1) << j);
    end
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("in_ready_during_reset", 32'(in_ready), 32'd0);
      exp_q.delete();
      m_cnt = 0;
      m_bits = '0;
      err_exp = 1'b0;
      prev_stall = 1'b0;
      after_rst = 1'b1;
    end else begin
      if (after_rst) begin
        chk("post_reset_cw_valid", 32'(cw_valid), 32'd0);
        chk("post_reset_cw_data", 32'(cw_data), 32'd0);
        chk("post_reset_in_ready", 32'(in_ready), 32'd1);
        after_rst = 1'b0;
      end
      chk("err_frame", 32'(err_frame), 32'(err_exp));
      if (err_frame) err_seen++;
      err_exp = 1'b0;
      if (prev_stall) begin
        chk("stall_cw_valid", 32'(cw_valid), 32'd1);
        chk("stall_cw_data", 32'(cw_data), 32'(prev_data));
      end
      if (cw_valid && cw_ready) begin
        out_data.push_back(cw_data);
        out_cyc.push_back(cyc);
        if (exp_q.size() == 0) chk("unexpected_codeword", 32'(cw_valid), 32'd0);
        else chk("cw_data", 32'(cw_data), 32'(exp_q.pop_front()));
      end
      prev_stall = cw_valid && !cw_ready;
      prev_data  = cw_data;
      if (in_valid && in_ready) begin
        if (in_bit) m_bits = m_bits | (K'(1) << m_cnt);
        m_cnt++;
        if (m_cnt == K) begin
          exp_q.push_back(encode(build_u(m_bits)));
          err_exp = !in_last;
          m_cnt = 0;
          m_bits = '0;
          last_beat_cyc = cyc;
        end else if (in_last) begin
          err_exp = 1'b1;
          m_cnt = 0;
          m_bits = '0;
        end
      end
    end
  end

  task automatic send_bit(input logic b, input logic last, output int waits);
    waits = 0;
    in_valid = 1'b1;
    in_bit   = b;
    in_last  = last;
    @(negedge clk);
    while (!in_ready && waits < 200) begin
      waits++;
      @(negedge clk);
    end
    if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [K-1:0] bits, input logic last_on_k, output int waits);
    int w;
    waits = 0;
    for (int k = 0; k < K; k++) begin
      send_bit(bits[k], (k == K - 1) ? last_on_k : 1'b0, w);
      waits += w;
    end
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_bit   = 1'b0;
  endtask

  task automatic wait_outputs(input int target, input int budget);
    int n;
    n = 0;
    while (out_data.size() < target && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (out_data.size() < target) chk("output_timeout", 32'(out_data.size()), 32'(target));
  endtask

  initial begin
    int w, tw, base, es;
    logic [K-1:0] t2_bits [3];
    logic [N-1:0] t2_exp  [3];
    t2_bits = '{4'b1000, 4'b1111, 4'b0000};
    t2_exp  = '{8'hFF, 8'h96, 8'h00};

    rst_n = 1'b0;
    cw_ready = 1'b1;
    idle();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    chk("model_u3", 32'(encode(build_u(4'b0001))), 32'h0F);
    chk("model_u7", 32'(encode(build_u(4'b1000))), 32'hFF);
    chk("model_all", 32'(encode(build_u(4'b1111))), 32'h96);
    chk("model_map", 32'(build_u(4'b0010)), 32'h20);

    // Single frame latency
    base = out_data.size();
    send_frame(4'b0001, 1'b1, w);
    idle();
    wait_outputs(base + 1, 30);
    chk("t1_data", 32'(out_data[base]), 32'h0F);
    chk("t1_latency", 32'(out_cyc[base] - last_beat_cyc), 32'd4);

    for (int t = 0; t < 3; t++) begin
      base = out_data.size();
      send_frame(t2_bits[t], 1'b1, w);
      idle();
      wait_outputs(base + 1, 30);
      chk("t2_data", 32'(out_data[base]), 32'(t2_exp[t]));
    end

    // K-th beat without in_last: still encoded, error flagged
    base = out_data.size();
    es = err_seen;
    send_frame(4'b0010, 1'b0, w);
    idle();
    wait_outputs(base + 1, 30);
    chk("kth_no_last_data", 32'(out_data[base]), 32'h33);
    chk("kth_no_last_err", 32'(err_seen - es), 32'd1);

    // Back-to-back frames
    base = out_data.size();
    tw = 0;
    for (int f = 0; f < 8; f++) begin
      send_frame(4'(f * 3 + 1), 1'b1, w);
      tw += w;
    end
    idle();
    chk("b2b_in_ready_stalls", 32'(tw), 32'd0);
    wait_outputs(base + 8, 60);
    for (int f = 1; f < 8; f++) begin
      chk("b2b_spacing", 32'(out_cyc[base + f] - out_cyc[base + f - 1]), 32'd4);
    end

    // Output stall while streaming
    base = out_data.size();
    tw = 0;
    fork
      begin
        cw_ready = 1'b0;
        repeat (30) @(posedge clk);
        #1 cw_ready = 1'b1;
      end
      begin
        int w2;
        for (int f = 0; f < 8; f++) begin
          send_frame(4'(f + 5), 1'b1, w2);
          tw += w2;
        end
        idle();
      end
    join
    chk("stall_in_ready_dropped", 32'(tw > 0), 32'd1);
    wait_outputs(base + 8, 100);
    chk("stall_count", 32'(out_data.size() - base), 32'd8);

    // Early in_last discards the partial frame
    base = out_data.size();
    es = err_seen;
    send_bit(1'b1, 1'b0, w);
    send_bit(1'b0, 1'b1, w);
    idle();
    repeat (2) @(posedge clk);
    #1;
    chk("early_last_err", 32'(err_seen - es), 32'd1);
    send_frame(4'b0001, 1'b1, w);
    idle();
    wait_outputs(base + 1, 30);
    chk("early_last_next", 32'(out_data[base]), 32'h0F);
    repeat (6) @(posedge clk);
    #1;
    chk("early_last_count", 32'(out_data.size() - base), 32'd1);

    // Reset with frames in flight
    cw_ready = 1'b0;
    send_frame(4'b1111, 1'b1, w);
    send_frame(4'b0110, 1'b1, w);
    idle();
    repeat (6) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    cw_ready = 1'b1;
    base = out_data.size();
    repeat (10) @(posedge clk);
    #1;
    chk("reset_no_stale", 32'(out_data.size() - base), 32'd0);
    send_frame(4'b1000, 1'b1, w);
    idle();
    wait_outputs(base + 1, 30);
    chk("reset_fresh", 32'(out_data[base]), 32'hFF);

    repeat (5) @(posedge clk);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
